// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall sequencer: hazard inputs from ID/EX
// and the write-enable / flush / hold controls back to the pipeline registers.
interface hazard_stall_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [4:0]             ID_Rs;
  logic [4:0]             ID_Rt;
  logic                   ID_UsesRs;
  logic                   ID_UsesRt;
  logic                   ID_Jump;
  logic [4:0]             EX_Rt;
  logic                   EX_MemRead;
  logic                   EX_BranchTaken;
  logic                   EX_MulDiv;
  logic                   PC_Write;
  logic                   IF_ID_Write;
  logic                   IF_Flush;
  logic                   ID_Flush;
  logic                   EX_Hold;
  logic                   EXMEM_Bubble;
  logic                   MulDiv_Start;
  logic                   MulDiv_Busy;
  logic [STALL_CNT_W-1:0] Stall_Count;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
           EX_Rt, EX_MemRead, EX_BranchTaken, EX_MulDiv,
    input  PC_Write, IF_ID_Write, IF_Flush, ID_Flush, EX_Hold,
           EXMEM_Bubble, MulDiv_Start, MulDiv_Busy, Stall_Count
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
           EX_Rt, EX_MemRead, EX_BranchTaken, EX_MulDiv,
    output PC_Write, IF_ID_Write, IF_Flush, ID_Flush, EX_Hold,
           EXMEM_Bubble, MulDiv_Start, MulDiv_Busy, Stall_Count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// wrong-path flushes, fixed-latency mult/div freeze and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned MULDIV_LAT  = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  hz
);
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 2);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic rs_hit, rt_hit, load_use;
  logic pc_write, if_id_write, if_flush, id_flush;
  logic ex_hold, exmem_bubble, muldiv_start, muldiv_busy;

  always_comb begin
    rs_hit   = hz.ID_UsesRs && (hz.ID_Rs == hz.EX_Rt);
    rt_hit   = hz.ID_UsesRt && (hz.ID_Rt == hz.EX_Rt);
    load_use = hz.EX_MemRead && (hz.EX_Rt != 5'd0) && (rs_hit || rt_hit);
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_start = 1'b0;
    muldiv_busy  = (state_q == BUSY);
    state_d      = state_q;
    cnt_d        = cnt_q;

    if (!rst) begin
      muldiv_busy = 1'b0;
      state_d     = RUN;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz.EX_MulDiv) begin
            muldiv_start = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_hold      = 1'b1;
            exmem_bubble = 1'b1;
            state_d      = BUSY;
            cnt_d        = CNT_LOAD;
          end else if (hz.EX_BranchTaken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (load_use) begin
            // A jump sitting in ID is held here rather than flushed; it
            // redirects on the following cycle once the bubble is in.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_flush    = 1'b1;
          end else if (hz.ID_Jump) begin
            if_flush = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_hold      = 1'b1;
            exmem_bubble = 1'b1;
            cnt_d        = cnt_q - 4'd1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.PC_Write     = pc_write;
  assign hz.IF_ID_Write  = if_id_write;
  assign hz.IF_Flush     = if_flush;
  assign hz.ID_Flush     = id_flush;
  assign hz.EX_Hold      = ex_hold;
  assign hz.EXMEM_Bubble = exmem_bubble;
  assign hz.MulDiv_Start = muldiv_start;
  assign hz.MulDiv_Busy  = muldiv_busy;
  assign hz.Stall_Count  = stall_cnt_q;
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage MIPS core. Sits beside the IF/ID, ID/EX and EX/MEM registers and drives their write-enable, flush and hold controls. Detects load-use hazards, flushes wrong-path instructions on taken branches and ID-stage jumps, and sequences a fixed-latency multi-cycle mult/div in EX by freezing the front of the pipe. Keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_LAT, 4, total EX occupancy in cycles of a mult/div instruction; legal range 2..16
STALL_CNT_W, 16, width of Stall_Count

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-low reset
ID_Rs  input  5  source register 1 of the instruction in ID
ID_Rt  input  5  source register 2 of the instruction in ID
ID_UsesRs  input  1  ID instruction reads Rs
ID_UsesRt  input  1  ID instruction reads Rt
ID_Jump  input  1  ID instruction is j/jal/jr/jalr (resolved in ID)
EX_Rt  input  5  Rt (load destination) of the instruction in EX
EX_MemRead  input  1  EX instruction is a load
EX_BranchTaken  input  1  EX branch resolved taken
EX_MulDiv  input  1  EX instruction is mult/multu/div/divu
PC_Write  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register write enable
IF_Flush  output  1  clear IF/ID to nop
ID_Flush  output  1  clear ID/EX to bubble (drives ID/EX flush input)
EX_Hold  output  1  ID/EX holds its current contents
EXMEM_Bubble  output  1  insert bubble into EX/MEM
MulDiv_Start  output  1  one-cycle start pulse to the mult/div unit
MulDiv_Busy  output  1  mult/div sequence in progress
Stall_Count  output  STALL_CNT_W  cycles with PC_Write=0, saturating

Behaviour:
- State: RUN, BUSY; down-counter cnt (4 bits); Stall_Count register. All registered, rising clk.
- Reset (rst=0 at clk edge): state=RUN, cnt=0, Stall_Count=0. While rst=0, outputs forced: PC_Write=1, IF_ID_Write=1, all others 0. Reset mid-BUSY aborts the sequence immediately; no Start re-issued.
- All control outputs combinational from state, cnt and inputs; zero-latency.
- Defaults: PC_Write=1, IF_ID_Write=1, IF_Flush=ID_Flush=EX_Hold=EXMEM_Bubble=MulDiv_Start=0; MulDiv_Busy=1 iff state=BUSY.
- RUN, priority high->low:
  1. EX_MulDiv=1: MulDiv_Start=1, PC_Write=0, IF_ID_Write=0, EX_Hold=1, EXMEM_Bubble=1; next state BUSY, cnt=MULDIV_LAT-2.
  2. EX_BranchTaken=1: IF_Flush=1, ID_Flush=1, PC_Write=1 (loads target). Overrides load-use and jump.
  3. Load-use: EX_MemRead=1 and EX_Rt!=0 and ((ID_UsesRs and ID_Rs==EX_Rt) or (ID_UsesRt and ID_Rt==EX_Rt)): PC_Write=0, IF_ID_Write=0, ID_Flush=1. Exactly one bubble per hazard. Jump in ID waits, is not flushed.
  4. ID_Jump=1: IF_Flush=1.
- BUSY, cnt!=0: PC_Write=0, IF_ID_Write=0, EX_Hold=1, EXMEM_Bubble=1; all hazard/flush inputs ignored; cnt decrements.
- BUSY, cnt==0: outputs at defaults (result ready, mul/div advances); next state RUN. Hazard inputs still ignored this cycle.
- Net: Start cycle plus (MULDIV_LAT-2) BUSY cycles stalled = MULDIV_LAT-1 stall cycles; EX occupancy MULDIV_LAT cycles. MULDIV_LAT=2: BUSY entered with cnt=0, one stall cycle.
- Stall_Count: +1 on each edge where PC_Write=0 and rst=1; holds at all-ones.

Test Plan:
- Load-use: lw $8 in EX (EX_MemRead=1, EX_Rt=8), ID_Rs=8, ID_UsesRs=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_Flush=1; next cycle (EX_MemRead=0) defaults; Stall_Count=1.
- No false stall: EX_Rt=0 with ID_Rs=0, or match with ID_UsesRt=0 -> PC_Write=1, ID_Flush=0, Stall_Count unchanged.
- Taken branch plus load-use match and ID_Jump same cycle -> IF_Flush=1, ID_Flush=1, PC_Write=1, IF_ID_Write=1.
- MULDIV_LAT=4: EX_MulDiv=1 in RUN -> cycle0 MulDiv_Start=1, stall; cycles1-2 Busy=1, stall, Start=0; cycle3 Busy=1, defaults; cycle4 RUN; Stall_Count=3; EX_BranchTaken pulsed in cycle1 ignored.
- Reset in cycle1 of mul/div sequence -> next cycle RUN, Busy=0, Stall_Count=0, PC_Write=1, no Start.
- STALL_CNT_W=4: 20 consecutive load-use stalls -> Stall_Count reaches 15 and stays 15.
